// File: rtl/mask_arb_pkg.sv
// Shared types and helpers for the mask_arb round-robin arbiter.
//   state_e       : arbiter FSM state (idle / grant outstanding)
//   lsb_onehot    : isolate the lowest set bit of a vector (one-hot result)
//   onehot_to_bin : binary index of a one-hot vector
// The helpers operate on MAX_W-bit vectors; callers zero-extend their
// W-bit operands and truncate the result back to W (or $clog2(W)) bits.
package mask_arb_pkg;

  localparam int MAX_W     = 32;
  localparam int MAX_ENC_W = 5;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Two's-complement trick: v & -v keeps only the lowest set bit.
  function automatic logic [MAX_W-1:0] lsb_onehot(input logic [MAX_W-1:0] v);
    return v & (~v + MAX_W'(1));
  endfunction

  function automatic logic [MAX_ENC_W-1:0] onehot_to_bin(input logic [MAX_W-1:0] oh);
    logic [MAX_ENC_W-1:0] b;
    b = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (oh[i]) b = b | MAX_ENC_W'(i);
    end
    return b;
  endfunction

endpackage

// File: rtl/mask_arb_pri_mask.sv
// pri_mask: combinational unary mask generator.
// Ports:
//   i_oh   [W-1:0] : one-hot position marker
//   o_mask [W-1:0] : bits on the UP (toward MSB) or down side of the marker,
//                    optionally including the marker bit itself (INCL)
module pri_mask #(
  parameter int W    = 4,
  parameter bit UP   = 1'b1,
  parameter bit INCL = 1'b0
) (
  input  logic [W-1:0] i_oh,
  output logic [W-1:0] o_mask
);

  always_comb begin
    o_mask = '0;
    for (int i = 0; i < W; i++) begin
      for (int j = 0; j < W; j++) begin
        if ((UP && (j < i)) || (!UP && (j > i)) || (INCL && (j == i))) begin
          o_mask[i] = o_mask[i] | i_oh[j];
        end
      end
    end
  end

endmodule

// File: rtl/mask_arb.sv
// mask_arb: W-way round-robin arbiter with registered one-hot grant.
// Parameters:
//   W    : number of requestors (2..32)
//   HOLD : 1 = winner keeps the grant across acks while still requesting
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   i_req  [W-1:0]    : level-sensitive requests
//   i_ack             : downstream accepts the current grant
//   o_gnt  [W-1:0]    : one-hot grant (zero when not valid)
//   o_gnt_vld         : grant valid
//   o_gnt_enc         : binary index of o_gnt (zero when not valid)
module mask_arb
  import mask_arb_pkg::*;
#(
  parameter int W    = 4,
  parameter bit HOLD = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [W-1:0]         i_req,
  input  logic                 i_ack,
  output logic [W-1:0]         o_gnt,
  output logic                 o_gnt_vld,
  output logic [$clog2(W)-1:0] o_gnt_enc
);

  localparam int ENC_W = $clog2(W);

  if (W < 2 || W > MAX_W) begin : g_w_check
    $error("mask_arb: W must be in 2..32");
  end

  state_e           state_q, state_d;
  logic [W-1:0]     ptr_q, ptr_d;
  logic [W-1:0]     gnt_q, gnt_d;
  logic [ENC_W-1:0] enc_q, enc_d;
  logic             vld_q, vld_d;

  logic [W-1:0]     mask_src;
  logic [W-1:0]     arb_mask;
  logic [W-1:0]     masked_req;
  logic [W-1:0]     winner;
  logic [ENC_W-1:0] winner_enc;
  logic             keep_grant;

  // In GRANT, re-arbitration only happens on an ack, where ptr becomes the
  // current grant in the same edge; using gnt_q directly gives the updated
  // priority without waiting a cycle for ptr_q.
  assign mask_src = (state_q == ST_GRANT) ? gnt_q : ptr_q;

  pri_mask #(
    .W   (W),
    .UP  (1'b1),
    .INCL(1'b0)
  ) u_pri_mask (
    .i_oh  (mask_src),
    .o_mask(arb_mask)
  );

  always_comb begin
    masked_req = i_req & arb_mask;
    // Nothing above the pointer: wrap around to the lowest requester.
    winner     = W'(lsb_onehot(MAX_W'((masked_req != '0) ? masked_req : i_req)));
    winner_enc = ENC_W'(onehot_to_bin(MAX_W'(winner)));
    keep_grant = HOLD && i_req[enc_q];
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    enc_d   = enc_q;
    vld_d   = vld_q;
    case (state_q)
      ST_IDLE: begin
        if (|i_req) begin
          state_d = ST_GRANT;
          gnt_d   = winner;
          enc_d   = winner_enc;
          vld_d   = 1'b1;
        end
      end
      ST_GRANT: begin
        if (i_ack) begin
          ptr_d = gnt_q;
          if (!keep_grant) begin
            if (|i_req) begin
              gnt_d = winner;
              enc_d = winner_enc;
            end else begin
              state_d = ST_IDLE;
              gnt_d   = '0;
              enc_d   = '0;
              vld_d   = 1'b0;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        enc_d   = '0;
        vld_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= {1'b1, {(W-1){1'b0}}};  // bit 0 gets top priority after reset
      gnt_q   <= '0;
      enc_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      enc_q   <= enc_d;
      vld_q   <= vld_d;
    end
  end

  assign o_gnt     = gnt_q;
  assign o_gnt_enc = enc_q;
  assign o_gnt_vld = vld_q;

endmodule

// File: tb/tb_mask_arb.sv
// Bench for mask_arb: one DUT with HOLD=0 and one with HOLD=1 share the same
// stimulus. A round-robin reference model (index search from the last winner)
// predicts both and is compared every cycle; directed literals pin the model.
module tb_mask_arb;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         ack;
  logic [W-1:0] req;

  logic [W-1:0] gnt0, gnt1;
  logic [1:0]   enc0, enc1;
  logic         vld0, vld1;

  int errors = 0;
  int checks = 0;

  int m_vld [2];
  int m_idx [2];
  int m_ptr [2];
  bit started = 1'b0;

  always #5 clk = ~clk;

  mask_arb #(.W(W), .HOLD(1'b0)) dut0 (
    .clk(clk), .rst(rst), .i_req(req), .i_ack(ack),
    .o_gnt(gnt0), .o_gnt_vld(vld0), .o_gnt_enc(enc0)
  );

  mask_arb #(.W(W), .HOLD(1'b1)) dut1 (
    .clk(clk), .rst(rst), .i_req(req), .i_ack(ack),
    .o_gnt(gnt1), .o_gnt_vld(vld1), .o_gnt_enc(enc1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // First requester found scanning upward from the position after 'base'.
  function automatic int rr_pick(input logic [W-1:0] r, input int base);
    int c;
    for (int k = 1; k <= W; k++) begin
      c = (base + k) % W;
      if (r[c]) return c;
    end
    return 0;
  endfunction

  // Compare outputs (state after the last rising edge), then advance the model
  // with the inputs that the next rising edge will sample.
  always @(negedge clk) begin
    if (started) begin
      chk("cyc_gnt0", {28'd0, gnt0}, m_vld[0] ? (32'd1 << m_idx[0]) : 32'd0);
      chk("cyc_enc0", {30'd0, enc0}, m_vld[0] ? m_idx[0] : 0);
      chk("cyc_vld0", {31'd0, vld0}, m_vld[0]);
      chk("cyc_gnt1", {28'd0, gnt1}, m_vld[1] ? (32'd1 << m_idx[1]) : 32'd0);
      chk("cyc_enc1", {30'd0, enc1}, m_vld[1] ? m_idx[1] : 0);
      chk("cyc_vld1", {31'd0, vld1}, m_vld[1]);
    end
    for (int h = 0; h < 2; h++) begin
      if (rst) begin
        m_vld[h] = 0;
        m_idx[h] = 0;
        m_ptr[h] = W - 1;
      end else if (m_vld[h] == 0) begin
        if (req != '0) begin
          m_idx[h] = rr_pick(req, m_ptr[h]);
          m_vld[h] = 1;
        end
      end else if (ack) begin
        m_ptr[h] = m_idx[h];
        if (h == 1 && req[m_idx[h]]) begin
          m_idx[h] = m_idx[h];
        end else if (req != '0) begin
          m_idx[h] = rr_pick(req, m_ptr[h]);
        end else begin
          m_vld[h] = 0;
          m_idx[h] = 0;
        end
      end
    end
    if (rst) started = 1'b1;
  end

  task automatic step(input logic [W-1:0] r, input logic a, input logic s);
    req = r;
    ack = a;
    rst = s;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input int h, input logic [3:0] eg,
                            input logic [1:0] ee, input logic ev);
    if (h == 0) begin
      chk({name, "_gnt0"}, {28'd0, gnt0}, {28'd0, eg});
      chk({name, "_enc0"}, {30'd0, enc0}, {30'd0, ee});
      chk({name, "_vld0"}, {31'd0, vld0}, {31'd0, ev});
    end else begin
      chk({name, "_gnt1"}, {28'd0, gnt1}, {28'd0, eg});
      chk({name, "_enc1"}, {30'd0, enc1}, {30'd0, ee});
      chk({name, "_vld1"}, {31'd0, vld1}, {31'd0, ev});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] r;
    logic         a, s;

    req = '0; ack = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    step(4'b0000, 1'b0, 1'b1);
    expect_out("reset", 0, 4'b0000, 2'd0, 1'b0);
    expect_out("reset", 1, 4'b0000, 2'd0, 1'b0);

    // First grant after reset goes to bit 0.
    step(4'b1111, 1'b0, 1'b0);
    expect_out("first", 0, 4'b0001, 2'd0, 1'b1);

    // Full request with ack every cycle rotates with no bubbles; HOLD keeps.
    step(4'b1111, 1'b1, 1'b0); expect_out("rot1", 0, 4'b0010, 2'd1, 1'b1);
    expect_out("hold_rot", 1, 4'b0001, 2'd0, 1'b1);
    step(4'b1111, 1'b1, 1'b0); expect_out("rot2", 0, 4'b0100, 2'd2, 1'b1);
    step(4'b1111, 1'b1, 1'b0); expect_out("rot3", 0, 4'b1000, 2'd3, 1'b1);
    step(4'b1111, 1'b1, 1'b0); expect_out("rot4", 0, 4'b0001, 2'd0, 1'b1);
    expect_out("hold_rot4", 1, 4'b0001, 2'd0, 1'b1);

    // Grant held without ack even when requests drop; ack then idles.
    step(4'b1111, 1'b1, 1'b0); expect_out("to2", 0, 4'b0010, 2'd1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(4'b0000, 1'b0, 1'b0);
      expect_out("noack_hold", 0, 4'b0010, 2'd1, 1'b1);
    end
    step(4'b0000, 1'b1, 1'b0);
    expect_out("ack_idle", 0, 4'b0000, 2'd0, 1'b0);
    expect_out("ack_idle", 1, 4'b0000, 2'd0, 1'b0);

    // Wrap-around from last winner 3.
    step(4'b1000, 1'b0, 1'b0); expect_out("g3", 0, 4'b1000, 2'd3, 1'b1);
    step(4'b0101, 1'b1, 1'b0); expect_out("wrap", 0, 4'b0001, 2'd0, 1'b1);
    expect_out("wrap", 1, 4'b0001, 2'd0, 1'b1);

    // HOLD=1 grant lock and release.
    step(4'b0100, 1'b1, 1'b0); expect_out("g2", 1, 4'b0100, 2'd2, 1'b1);
    step(4'b0111, 1'b1, 1'b0); expect_out("lock", 1, 4'b0100, 2'd2, 1'b1);
    expect_out("nolock", 0, 4'b0001, 2'd0, 1'b1);
    step(4'b0011, 1'b1, 1'b0); expect_out("release", 1, 4'b0001, 2'd0, 1'b1);
    expect_out("after", 0, 4'b0010, 2'd1, 1'b1);

    // Reset beats ack mid-grant; then a fresh request is served.
    step(4'b0100, 1'b1, 1'b0); expect_out("pre_rst", 0, 4'b0100, 2'd2, 1'b1);
    step(4'b1111, 1'b1, 1'b1);
    expect_out("rst_mid", 0, 4'b0000, 2'd0, 1'b0);
    expect_out("rst_mid", 1, 4'b0000, 2'd0, 1'b0);
    step(4'b1000, 1'b0, 1'b0); expect_out("post_rst", 0, 4'b1000, 2'd3, 1'b1);

    // Sole requestor that is the current winner wins again.
    step(4'b1000, 1'b1, 1'b0); expect_out("sole", 0, 4'b1000, 2'd3, 1'b1);

    // Randomized traffic, checked every cycle by the model.
    for (int n = 0; n < 600; n++) begin
      if (n < 300) r = W'($urandom_range(0, 15));
      else         r = W'($urandom_range(0, 15) & $urandom_range(0, 15));
      a = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 59) == 0);
      step(r, a, s);
    end

    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    @(negedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mask_arb.md
MASK_ARB -- requirements
Module: mask_arb

Interface
REQ-001 Parameter W, default 4: number of requestors; W >= 2 SHALL be enforced at elaboration.
REQ-002 Parameter HOLD, default 'b0: 1 = grant lock, so the winner keeps the grant across acks while it keeps requesting.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 i_req  input  W  per-requestor request, level-sensitive.
REQ-006 i_ack  input  1  downstream accepts the current grant; ignored when o_gnt_vld=0.
REQ-007 o_gnt  output  W  registered one-hot grant; all-zero when o_gnt_vld=0.
REQ-008 o_gnt_vld  output  1  registered; grant valid.
REQ-009 o_gnt_enc  output  $clog2(W)  registered binary index of o_gnt; 0 when o_gnt_vld=0.

Function
REQ-010 Two-state FSM, IDLE and GRANT; o_gnt_vld=1 exactly in GRANT.
REQ-011 Priority pointer ptr: W-bit one-hot register holding the last acked winner.
REQ-012 Arbitration mask: bits strictly above ptr (toward MSB, exclusive of ptr).
REQ-013 Masked request: i_req AND the arbitration mask.
REQ-014 Winner: lowest set bit of the masked request if it is non-zero, else the lowest set bit of i_req (wrap-around).
REQ-015 IDLE with i_req=0: stay in IDLE, outputs zero.
REQ-016 IDLE with i_req!=0: register the winner into o_gnt/o_gnt_enc and enter GRANT next cycle; latency is one cycle from request to o_gnt_vld.
REQ-017 GRANT with i_ack=0: o_gnt, o_gnt_enc and ptr SHALL hold, even if i_req drops, including the granted bit.
REQ-018 GRANT with i_ack=1: ptr <= o_gnt in the same edge.
REQ-019 Ack, HOLD=0: re-arbitrate in the ack cycle using the updated-priority rule (mask computed from the current o_gnt, so the current winner has lowest priority).
REQ-020 On that re-arbitration, load the new winner and stay in GRANT if i_req!=0, else return to IDLE with outputs zeroed; back-to-back grants need no bubble.
REQ-021 Ack, HOLD=1, i_req[o_gnt_enc]=1: grant unchanged, stay in GRANT, ptr still updated.
REQ-022 Ack, HOLD=1, i_req[o_gnt_enc]=0: behave per REQ-019/REQ-020.
REQ-023 A sole requestor that is also the current winner SHALL win again on ack.
REQ-024 o_gnt SHALL never be non-one-hot while o_gnt_vld=1.
REQ-025 o_gnt SHALL never be non-zero while o_gnt_vld=0.

Reset
REQ-026 On rst: state=IDLE; o_gnt=0, o_gnt_vld=0, o_gnt_enc=0.
REQ-027 On rst: ptr=bit W-1, so that bit 0 has highest priority after reset.
REQ-028 rst SHALL take priority over i_ack and i_req in the same cycle, including mid-grant; the pending grant is discarded.

Structure
REQ-029 Package holds the FSM state enum and a W-parametrised function for lowest-set-bit-to-one-hot and one-hot-to-binary.
REQ-030 One sub-module pri_mask SHALL generate the unary mask from a one-hot vector, parametrised by W, direction and inclusivity, purely combinational.
REQ-031 All other logic is local to mask_arb; all outputs driven directly from flops.

Verification (W=4 unless stated)
REQ-032 Reset then i_req=4'b1111 -> next cycle o_gnt=4'b0001, o_gnt_enc=0, o_gnt_vld=1.
REQ-033 i_req=4'b1111 held, i_ack=1 every cycle -> o_gnt sequence 0001,0010,0100,1000,0001 with no bubble cycles.
REQ-034 o_gnt=0010, i_ack=0, i_req drops to 0000 for 5 cycles -> o_gnt=0010 and o_gnt_vld=1 throughout; then ack -> IDLE, outputs zero.
REQ-035 ptr=1000 (last ack idx 3), i_req=0101, ack -> next o_gnt=0001 (wrap-around).
REQ-036 HOLD=1, o_gnt=0100, ack with i_req=0111 -> o_gnt stays 0100; ack with i_req=0011 -> o_gnt=0001.
REQ-037 rst asserted while o_gnt=0100 and i_ack=1 -> next cycle all outputs zero; then i_req=1000 -> o_gnt=1000.
